// File: rtl/ram_pkg.sv
// ram_pkg
// Shared constants, helpers and types for the tiled 1rw1r SRAM wrapper.
// The macro geometry constants describe one sky130_sram_1kbyte_1rw1r_32x256_8
// tile. The read payload struct carries everything captured in the macro
// cycle (stage 0) that is needed to build the returned word one cycle later.
package ram_pkg;

    localparam int MACRO_WIDTH  = 32;
    localparam int MACRO_DEPTH  = 256;
    localparam int MACRO_ADDR_W = 8;
    localparam int MACRO_MASK_W = 4;

    // Upper bound on the word width a wrapper instance may use. The payload
    // struct has to have a fixed width, so forwarded data is stored at this
    // size and only the low DATA_WIDTH bits are ever meaningful.
    localparam int MAX_DATA_WIDTH = 512;
    localparam int MAX_MASK_W     = MAX_DATA_WIDTH / 8;

    // Bank index is taken from a 32-bit zero-extended address shifted by
    // the macro row width, which leaves 24 bits of bank index.
    localparam int BANK_IDX_W = 32 - MACRO_ADDR_W;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    typedef struct packed {
        logic                      valid;
        logic                      err;
        logic [BANK_IDX_W-1:0]     bank;
        logic                      coll;
        logic [MAX_DATA_WIDTH-1:0] fwd_data;
        logic [MAX_MASK_W-1:0]     fwd_mask;
    } rd_payload_t;

endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe
// DELAY-stage valid/data shift pipeline placed after the macro read cycle.
//   clk_i, reset_i     : clock, synchronous active-high reset (clears valids)
//   valid_i, data_i    : entry into the first stage
//   valid_o, data_o    : output of the last stage (input when DELAY == 0)
module ram_rd_pipe #(
    parameter int DELAY = 0,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    if (DELAY == 0) begin : g_bypass
        assign valid_o = valid_i;
        assign data_o  = data_i;
    end else begin : g_stages
        logic [DELAY-1:0] valid_q;
        logic [WIDTH-1:0] data_q [DELAY];

        // Only the valid bits need reset; data is qualified by them.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                valid_q <= '0;
            end else begin
                valid_q[0] <= valid_i;
                for (int i = 1; i < DELAY; i++) begin
                    valid_q[i] <= valid_q[i-1];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            data_q[0] <= data_i;
            for (int i = 1; i < DELAY; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end

        assign valid_o = valid_q[DELAY-1];
        assign data_o  = data_q[DELAY-1];
    end

endmodule

// File: rtl/sky130_sram_1kbyte_1rw1r_32x256_8.sv
// sky130_sram_1kbyte_1rw1r_32x256_8
// Behavioural model of the 32x256 1rw1r SRAM macro, limited to the pins the
// tiled wrapper drives: port 0 is used write-only, port 1 read-only.
//   clk0/csb0/web0/wmask0/addr0/din0 : port 0 (active-low select/write)
//   clk1/csb1/addr1/dout1             : port 1 (active-low select, read)
// A same-address read and write in one cycle returns the old word; the
// wrapper never relies on that for bytes it forwards itself.
module sky130_sram_1kbyte_1rw1r_32x256_8 (
    input  logic        clk0,
    input  logic        csb0,
    input  logic        web0,
    input  logic [3:0]  wmask0,
    input  logic [7:0]  addr0,
    input  logic [31:0] din0,
    input  logic        clk1,
    input  logic        csb1,
    input  logic [7:0]  addr1,
    output logic [31:0] dout1
);

    logic [31:0] mem [256];

    // Byte-masked write on port 0.
    always_ff @(posedge clk0) begin
        if (!csb0 && !web0) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask0[i]) begin
                    mem[addr0][i*8 +: 8] <= din0[i*8 +: 8];
                end
            end
        end
    end

    // Registered read on port 1; dout1 holds while the port is deselected.
    always_ff @(posedge clk1) begin
        if (!csb1) begin
            dout1 <= mem[addr1];
        end
    end

endmodule

// File: rtl/ram_sync_1rw1r_tiled.sv
// ram_sync_1rw1r_tiled
// Tiled 1rw1r synchronous RAM built from 32x256 sky130 macros, with byte
// write mask, per-byte write-first forwarding on same-address collisions,
// a configurable read pipeline and out-of-range error flags.
//   clk, reset            : clock, synchronous active-high reset
//   wen/wadr/wdata/wmask  : write port with byte enables
//   ren/radr              : read request
//   rdata/rvalid/rerr     : read response 1+DELAY cycles after ren; rdata
//                           holds between responses
//   werr                  : pulse the cycle after an out-of-range write
module ram_sync_1rw1r_tiled
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int DELAY      = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wen,
    input  logic [ADDR_WIDTH-1:0]   wadr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wmask,
    input  logic                    ren,
    input  logic [ADDR_WIDTH-1:0]   radr,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    output logic                    rerr,
    output logic                    werr
);

    localparam int NC         = ceil_div(DATA_WIDTH, MACRO_WIDTH);
    localparam int NB         = ceil_div(DEPTH, MACRO_DEPTH);
    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int PAD_W      = NC * MACRO_WIDTH;
    localparam int PAD_MASK_W = NC * MACRO_MASK_W;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_badWidth
        $error("ram_sync_1rw1r_tiled: DATA_WIDTH must be a multiple of 8 in 8..%0d", MAX_DATA_WIDTH);
    end
    if (DELAY < 0 || DELAY > 4) begin : g_badDelay
        $error("ram_sync_1rw1r_tiled: DELAY must be 0..4");
    end
    if (DEPTH < 1 || ADDR_WIDTH > 32 || longint'(DEPTH) > (longint'(1) << ADDR_WIDTH)) begin : g_badDepth
        $error("ram_sync_1rw1r_tiled: DEPTH does not fit ADDR_WIDTH");
    end

    // Addresses are widened to 32 bits so bank/row extraction works for any
    // ADDR_WIDTH, including widths below the macro row width.
    logic [31:0]           wadrExt, radrExt;
    logic                  wInRange, rInRange, wAccept;
    logic [BANK_IDX_W-1:0] wBank, rBank;
    logic [PAD_W-1:0]      wdataPad;
    logic [PAD_MASK_W-1:0] wmaskPad;

    assign wadrExt  = 32'(wadr);
    assign radrExt  = 32'(radr);
    assign wInRange = wadrExt < 32'(DEPTH);
    assign rInRange = radrExt < 32'(DEPTH);
    assign wAccept  = wen && wInRange;
    assign wBank    = wadrExt[31:MACRO_ADDR_W];
    assign rBank    = radrExt[31:MACRO_ADDR_W];
    // Zero extension keeps the pad bytes of a partial column tile masked off.
    assign wdataPad = PAD_W'(wdata);
    assign wmaskPad = PAD_MASK_W'(wmask);

    logic [MACRO_WIDTH-1:0] macroDout [NB][NC];

    for (genvar gb = 0; gb < NB; gb++) begin : g_bank
        logic wSel, rSel;
        assign wSel = wAccept && (wBank == BANK_IDX_W'(gb));
        assign rSel = ren && rInRange && (rBank == BANK_IDX_W'(gb));
        for (genvar gc = 0; gc < NC; gc++) begin : g_col
            sky130_sram_1kbyte_1rw1r_32x256_8 uMacro (
                .clk0   (clk),
                .csb0   (~wSel),
                .web0   (~wSel),
                .wmask0 (wmaskPad[gc*MACRO_MASK_W +: MACRO_MASK_W]),
                .addr0  (wadrExt[MACRO_ADDR_W-1:0]),
                .din0   (wdataPad[gc*MACRO_WIDTH +: MACRO_WIDTH]),
                .clk1   (clk),
                .csb1   (~rSel),
                .addr1  (radrExt[MACRO_ADDR_W-1:0]),
                .dout1  (macroDout[gb][gc])
            );
        end
    end

    // Stage 0 captures the request alongside the macro access. On a
    // same-address collision the write data and mask are kept so the
    // written bytes can override the macro output, which is unreliable then.
    rd_payload_t stage0_d, stage0_q;

    always_comb begin
        stage0_d       = '0;
        stage0_d.valid = ren;
        stage0_d.err   = !rInRange;
        stage0_d.bank  = rBank;
        stage0_d.coll  = ren && wen && rInRange && wInRange && (radr == wadr);
        if (stage0_d.coll) begin
            stage0_d.fwd_data[DATA_WIDTH-1:0] = wdata;
            stage0_d.fwd_mask[BYTES-1:0]      = wmask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage0_q <= '0;
        end else begin
            stage0_q <= stage0_d;
        end
    end

    // Pick the addressed bank, drop pad bits, merge forwarded bytes and
    // zero the word for out-of-range reads.
    logic [PAD_W-1:0]      bankWord;
    logic [DATA_WIDTH-1:0] mergedData;

    always_comb begin
        bankWord = '0;
        for (int b = 0; b < NB; b++) begin
            if (stage0_q.bank == BANK_IDX_W'(b)) begin
                for (int c = 0; c < NC; c++) begin
                    bankWord[c*MACRO_WIDTH +: MACRO_WIDTH] = macroDout[b][c];
                end
            end
        end
    end

    always_comb begin
        mergedData = bankWord[DATA_WIDTH-1:0];
        for (int i = 0; i < BYTES; i++) begin
            if (stage0_q.fwd_mask[i]) begin
                mergedData[i*8 +: 8] = stage0_q.fwd_data[i*8 +: 8];
            end
        end
        if (stage0_q.err) begin
            mergedData = '0;
        end
    end

    logic                  pipeValid;
    logic [DATA_WIDTH:0]   pipeData;

    ram_rd_pipe #(
        .DELAY (DELAY),
        .WIDTH (DATA_WIDTH + 1)
    ) uRdPipe (
        .clk_i   (clk),
        .reset_i (reset),
        .valid_i (stage0_q.valid),
        .data_i  ({stage0_q.err, mergedData}),
        .valid_o (pipeValid),
        .data_o  (pipeData)
    );

    // rdata shows the fresh word in the response cycle and the held copy
    // otherwise, so it changes only when rvalid is high.
    logic [DATA_WIDTH-1:0] rdataHold_q;
    logic                  werr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdataHold_q <= '0;
        end else if (pipeValid) begin
            rdataHold_q <= pipeData[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            werr_q <= 1'b0;
        end else begin
            werr_q <= wen && !wInRange;
        end
    end

    assign rvalid = pipeValid;
    assign rerr   = pipeValid && pipeData[DATA_WIDTH];
    assign rdata  = pipeValid ? pipeData[DATA_WIDTH-1:0] : rdataHold_q;
    assign werr   = werr_q;

endmodule

// File: tb/tb_ram_sync_1rw1r_tiled.sv
// tb_ram_sync_1rw1r_tiled
// Three wrapper configurations share one clock and reset:
//   A: 32x256, DELAY=0   B: 48x600, DELAY=2   C: 32x256, DELAY=3
// Issued reads push their expected word into a per-instance queue; a monitor
// pops and compares whenever an instance presents rvalid.
module tb_ram_sync_1rw1r_tiled;

    typedef struct {
        logic [63:0] data;
        logic [63:0] care;
        logic        err;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    exp_t qA[$];
    exp_t qB[$];
    exp_t qC[$];
    exp_t mon;

    logic        aWen, aRen, aRvalid, aRerr, aWerr;
    logic [7:0]  aWadr, aRadr;
    logic [31:0] aWdata, aRdata;
    logic [3:0]  aWmask;

    logic        bWen, bRen, bRvalid, bRerr, bWerr;
    logic [9:0]  bWadr, bRadr;
    logic [47:0] bWdata, bRdata;
    logic [5:0]  bWmask;

    logic        cWen, cRen, cRvalid, cRerr, cWerr;
    logic [7:0]  cWadr, cRadr;
    logic [31:0] cWdata, cRdata;
    logic [3:0]  cWmask;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ram_sync_1rw1r_tiled #(.DATA_WIDTH(32), .DEPTH(256), .DELAY(0)) dutA (
        .clk(clk), .reset(reset), .wen(aWen), .wadr(aWadr), .wdata(aWdata),
        .wmask(aWmask), .ren(aRen), .radr(aRadr), .rdata(aRdata),
        .rvalid(aRvalid), .rerr(aRerr), .werr(aWerr)
    );

    ram_sync_1rw1r_tiled #(.DATA_WIDTH(48), .DEPTH(600), .DELAY(2)) dutB (
        .clk(clk), .reset(reset), .wen(bWen), .wadr(bWadr), .wdata(bWdata),
        .wmask(bWmask), .ren(bRen), .radr(bRadr), .rdata(bRdata),
        .rvalid(bRvalid), .rerr(bRerr), .werr(bWerr)
    );

    ram_sync_1rw1r_tiled #(.DATA_WIDTH(32), .DEPTH(256), .DELAY(3)) dutC (
        .clk(clk), .reset(reset), .wen(cWen), .wadr(cWadr), .wdata(cWdata),
        .wmask(cWmask), .ren(cRen), .radr(cRadr), .rdata(cRdata),
        .rvalid(cRvalid), .rerr(cRerr), .werr(cWerr)
    );

    // Compare only the bits selected by care.
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp, input logic [63:0] care);
        checks++;
        if (((act ^ exp) & care) != 64'd0) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (care 0x%0h) at cycle %0d",
                     name, act & care, exp & care, care, cyc);
        end
    endtask

    // Drive one cycle of stimulus on the selected instance and, for a read,
    // queue the word it must return 1+DELAY cycles later.
    task automatic applyStimulus(input int dut, input logic wen, input int wadr,
                                 input logic [63:0] wdata, input logic [7:0] wmask,
                                 input logic ren, input int radr,
                                 input logic [63:0] expData, input logic [63:0] expCare,
                                 input logic expErr);
        exp_t e;
        case (dut)
            0: begin
                aWen = wen; aWadr = 8'(wadr); aWdata = 32'(wdata); aWmask = 4'(wmask);
                aRen = ren; aRadr = 8'(radr);
            end
            1: begin
                bWen = wen; bWadr = 10'(wadr); bWdata = 48'(wdata); bWmask = 6'(wmask);
                bRen = ren; bRadr = 10'(radr);
            end
            default: begin
                cWen = wen; cWadr = 8'(wadr); cWdata = 32'(wdata); cWmask = 4'(wmask);
                cRen = ren; cRadr = 8'(radr);
            end
        endcase
        @(posedge clk);
        #1;
        if (ren) begin
            e.data = expData;
            e.care = expCare;
            e.err  = expErr;
            case (dut)
                0: begin e.due = cyc;     qA.push_back(e); end
                1: begin e.due = cyc + 2; qB.push_back(e); end
                default: begin e.due = cyc + 3; qC.push_back(e); end
            endcase
        end
        aWen = 1'b0; aRen = 1'b0;
        bWen = 1'b0; bRen = 1'b0;
        cWen = 1'b0; cRen = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wait, bounded, for every queued read to be returned.
    task automatic drain(input string name);
        for (int i = 0; i < 50 && (qA.size() + qB.size() + qC.size()) != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput(name, 64'(qA.size() + qB.size() + qC.size()), 64'd0, '1);
    endtask

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge clk) begin
        if (aRvalid) begin
            if (qA.size() == 0) begin
                checkOutput("A unexpected rvalid", 64'd1, 64'd0, '1);
            end else begin
                mon = qA.pop_front();
                checkOutput("A rdata", 64'(aRdata), mon.data, mon.care);
                checkOutput("A rerr", 64'(aRerr), 64'(mon.err), '1);
                checkOutput("A latency", 64'(cyc), 64'(mon.due), '1);
            end
        end
        if (bRvalid) begin
            if (qB.size() == 0) begin
                checkOutput("B unexpected rvalid", 64'd1, 64'd0, '1);
            end else begin
                mon = qB.pop_front();
                checkOutput("B rdata", 64'(bRdata), mon.data, mon.care);
                checkOutput("B rerr", 64'(bRerr), 64'(mon.err), '1);
                checkOutput("B latency", 64'(cyc), 64'(mon.due), '1);
            end
        end
        if (cRvalid) begin
            if (qC.size() == 0) begin
                checkOutput("C unexpected rvalid", 64'd1, 64'd0, '1);
            end else begin
                mon = qC.pop_front();
                checkOutput("C rdata", 64'(cRdata), mon.data, mon.care);
                checkOutput("C rerr", 64'(cRerr), 64'(mon.err), '1);
                checkOutput("C latency", 64'(cyc), 64'(mon.due), '1);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    localparam logic [63:0] ALL32 = 64'hFFFF_FFFF;
    localparam logic [63:0] ALL48 = 64'hFFFF_FFFF_FFFF;

    initial begin
        reset = 1'b1;
        aWen = 0; aRen = 0; aWadr = 0; aRadr = 0; aWdata = 0; aWmask = 0;
        bWen = 0; bRen = 0; bWadr = 0; bRadr = 0; bWdata = 0; bWmask = 0;
        cWen = 0; cRen = 0; cWadr = 0; cRadr = 0; cWdata = 0; cWmask = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("A reset rdata", 64'(aRdata), 64'd0, '1);
        checkOutput("A reset rvalid", 64'(aRvalid), 64'd0, '1);
        checkOutput("A reset rerr", 64'(aRerr), 64'd0, '1);
        checkOutput("A reset werr", 64'(aWerr), 64'd0, '1);
        checkOutput("B reset rdata", 64'(bRdata), 64'd0, '1);
        checkOutput("B reset rvalid", 64'(bRvalid), 64'd0, '1);
        checkOutput("C reset rdata", 64'(cRdata), 64'd0, '1);
        checkOutput("C reset rvalid", 64'(cRvalid), 64'd0, '1);
        reset = 1'b0;

        $display("[TB] A: basic write/read, concurrent different-address access");
        applyStimulus(0, 1, 'h10, 64'hDEADBEEF, 8'hF, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 'h10, 64'hDEADBEEF, ALL32, 0);
        applyStimulus(0, 1, 'h11, 64'h0BADF00D, 8'hF, 1, 'h10, 64'hDEADBEEF, ALL32, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 'h11, 64'h0BADF00D, ALL32, 0);

        $display("[TB] A: byte mask");
        applyStimulus(0, 1, 'h20, 64'h11223344, 8'hF, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 'h20, 64'hAABBCCDD, 8'h5, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 'h20, 64'h11BB33DD, ALL32, 0);

        $display("[TB] A: same-address collision forwarding");
        applyStimulus(0, 1, 5, 64'h11223344, 8'hF, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 5, 64'hAABBCCDD, 8'hF, 1, 5, 64'hAABBCCDD, ALL32, 0);
        applyStimulus(0, 1, 5, 64'h11223344, 8'hF, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 5, 64'hAABBCCDD, 8'h3, 1, 5, 64'h0000CCDD, 64'hFFFF, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 5, 64'h1122CCDD, ALL32, 0);

        $display("[TB] A: rdata hold while writing the same address");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 5, 64'h5A5A5A00 + 64'(i), 8'hF, 0, 0, 0, 0, 0);
            checkOutput("A hold rdata", 64'(aRdata), 64'h1122CCDD, '1);
            checkOutput("A hold rvalid", 64'(aRvalid), 64'd0, '1);
        end

        $display("[TB] B: partial tiles, multiple banks, range errors");
        applyStimulus(1, 1, 599, 64'h123456789ABC, 8'h3F, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 256, 64'hFFFF00000000, 8'h3F, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 188, 64'h0000CAFEF00D, 8'h3F, 0, 0, 0, 0, 0);
        checkOutput("B werr in range", 64'(bWerr), 64'd0, '1);
        applyStimulus(1, 0, 0, 0, 0, 1, 599, 64'h123456789ABC, ALL48, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 256, 64'hFFFF00000000, ALL48, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 600, 64'd0, ALL48, 1);
        applyStimulus(1, 1, 700, 64'h777777777777, 8'h3F, 0, 0, 0, 0, 0);
        checkOutput("B werr pulse", 64'(bWerr), 64'd1, '1);
        applyStimulus(1, 0, 0, 0, 0, 1, 599, 64'h123456789ABC, ALL48, 0);
        checkOutput("B werr clears", 64'(bWerr), 64'd0, '1);
        applyStimulus(1, 0, 0, 0, 0, 1, 256, 64'hFFFF00000000, ALL48, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 188, 64'h0000CAFEF00D, ALL48, 0);
        drain("drain before reset test");

        $display("[TB] C: reset with reads in flight");
        applyStimulus(2, 1, 1, 64'h01010101, 8'hF, 0, 0, 0, 0, 0);
        applyStimulus(2, 1, 2, 64'h02020202, 8'hF, 0, 0, 0, 0, 0);
        applyStimulus(2, 1, 3, 64'h03030303, 8'hF, 0, 0, 0, 0, 0);
        cRen = 1'b1; cRadr = 8'd1; @(posedge clk); #1;
        cRadr = 8'd2;              @(posedge clk); #1;
        cRadr = 8'd3;              @(posedge clk); #1;
        cRen = 1'b0;
        reset = 1'b1;
        cWen = 1'b1; cWadr = 8'd4; cWdata = 32'h04040404; cWmask = 4'hF;
        @(posedge clk); #1;
        reset = 1'b0;
        cWen = 1'b0;
        checkOutput("C post-reset rdata", 64'(cRdata), 64'd0, '1);
        checkOutput("C post-reset rvalid", 64'(cRvalid), 64'd0, '1);
        checkOutput("C post-reset rerr", 64'(cRerr), 64'd0, '1);
        checkOutput("C post-reset werr", 64'(cWerr), 64'd0, '1);
        for (int i = 0; i < 6; i++) begin
            idle(1);
            checkOutput("C no rvalid after reset", 64'(cRvalid), 64'd0, '1);
        end
        applyStimulus(2, 0, 0, 0, 0, 1, 2, 64'h02020202, ALL32, 0);
        applyStimulus(2, 0, 0, 0, 0, 1, 4, 64'h04040404, ALL32, 0);
        drain("final drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_sync_1rw1r_tiled.md
Name: ram_sync_1rw1r_tiled

Overview:
Parametrised successor to the single-bank 1rw1r SRAM wrapper. It tiles sky130_sram_1kbyte_1rw1r_32x256_8 macros for any DATA_WIDTH and DEPTH, including sizes that are not multiples of 32 or 256; partial tiles are zero-padded. On top of the raw macros it adds:
- a byte write mask;
- write-first forwarding when a read and a write hit the same address in the same cycle;
- a configurable read pipeline with rvalid;
- out-of-range error flags.

It serves as the common storage primitive for the accelerator's vector and matrix buffers.

Parameters:
DATA_WIDTH, 32, word width in bits (>=8, multiple of 8)
DEPTH, 256, number of words (>=1)
ADDR_WIDTH, $clog2(DEPTH) min 1, address width
DELAY, 0, extra registered read stages after the macro (0..4)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
wen  in  1  write enable
wadr  in  ADDR_WIDTH  write address
wdata  in  DATA_WIDTH  write data
wmask  in  DATA_WIDTH/8  byte write enables
ren  in  1  read enable
radr  in  ADDR_WIDTH  read address
rdata  out  DATA_WIDTH  read data, held between reads
rvalid  out  1  one-cycle pulse, rdata valid
rerr  out  1  with rvalid: read address out of range
werr  out  1  one-cycle pulse: write address out of range, write dropped

Behaviour:
- Clock and reset:
  - One clock, named clk.
  - reset is synchronous and active-high.
  - Reset values: rdata=0, rvalid=0, rerr=0, werr=0; all pipeline valid bits cleared.
  - Memory contents are not reset.
- Tiling:
  - Column tiles NC=ceil(DATA_WIDTH/32); bank tiles NB=ceil(DEPTH/256).
  - Bank index is adr>>8 and row is adr[7:0]; when ADDR_WIDTH<8 the row is the address zero-extended.
- Write path:
  - A write is accepted when wen=1 and wadr<DEPTH.
  - Only the addressed bank's macros get csb0/web0 low.
  - Macro wmask0 is taken from wmask, 4 bits per column tile; pad bytes are always masked off.
  - When wen=1 and wadr>=DEPTH, no macro is enabled and werr=1 on the next cycle.
- Read path:
  - A read is accepted when ren=1. Only the addressed bank's port 1 is enabled, and only when radr<DEPTH.
  - Stage 0 (the macro cycle) registers: valid, bank index, error flag, a collision flag, and forwarded write data plus mask.
  - Collision: ren and wen in the same cycle with radr==wadr, both in range. The macro output is then treated as undefined. The returned word has masked-on bytes taken from wdata and masked-off bytes from the macro, which may still hold stale/old data (write-first per byte).
  - The mux selects the bank output using the registered bank index; pad bits are dropped.
- Latency and outputs:
  - rvalid and rerr pulse exactly 1+DELAY cycles after an accepted read.
  - rdata updates only on that cycle; an out-of-range read gives rdata=0 with rerr=1.
  - Back-to-back reads are fully pipelined at one per cycle with no stall.
  - rdata holds its last value while no rvalid is asserted.
- Reset mid-operation: all in-flight reads are discarded, with no rvalid after reset deasserts. Writes issued in the reset cycle are still performed if in range; werr is forced 0.
- Simultaneous read and write to different addresses in the same bank is legal (1rw1r); no forwarding applies.
- Elaboration error if DATA_WIDTH%8!=0, DELAY>4, or DEPTH>2**ADDR_WIDTH.

Decomposition:
- Package ram_pkg:
  - constants MACRO_WIDTH=32, MACRO_DEPTH=256, MACRO_ADDR_W=8, MACRO_MASK_W=4;
  - function ceil_div;
  - typedef for the read pipeline payload struct: valid, err, bank, coll, fwd_data, fwd_mask.
- Sub-module ram_rd_pipe: a parametrised DELAY-stage valid/data shift pipeline with synchronous reset. It is instantiated once for the output stages.

Test Plan:
- DATA_WIDTH=32, DEPTH=256, DELAY=0: write 0xDEADBEEF @0x10, then read 0x10 -> rvalid one cycle after ren, rdata=0xDEADBEEF, rerr=0.
- DATA_WIDTH=48, DEPTH=600, DELAY=2: write 0x123456789ABC @599 and 0xFFFF00000000 @256; read 599 then 256 on consecutive cycles -> rvalid at +3 and +4 with those values. Read 600 -> rerr=1, rdata=0; write 700 -> werr pulse, memory unchanged.
- Byte mask: write 0x11223344 full, then write 0xAABBCCDD with wmask=4'b0101 -> read returns 0x11BB33DD.
- Collision: @5 holds 0x11223344; same-cycle wen, ren at 5 with wdata 0xAABBCCDD, wmask=4'b1111 -> rdata=0xAABBCCDD. Repeat with wmask=4'b0011 -> low 16 bits =0xCCDD.
- Reset mid-flight: DELAY=3, issue 3 reads, assert reset one cycle -> no rvalid ever for them; outputs 0. A following read returns the correct data.
- Hold: after a read returns X, idle 10 cycles with writes to the same address -> rdata stays X, rvalid stays 0.
